karatsuba_acc: RTL and testbench
================================

KARATSUBA_ACC -- requirements
Module: karatsuba_acc

Interface
REQ-001 SHALL have parameter N, default 16, meaning operand width of the upstream Karatsuba multiplier (product width 2*N).
REQ-002 SHALL have parameter G, default 8, meaning accumulator guard bits; ACC_W = 2*N+G.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port p  input  2*N  unsigned product from the multiplier.
REQ-006 SHALL have port p_valid  input  1  p and p_last are valid.
REQ-007 SHALL have port p_last  input  1  this product is the final term of the current sum.
REQ-008 SHALL have port p_ready  output  1  the block accepts a product this cycle.
REQ-009 SHALL have port acc  output  ACC_W  completed sum.
REQ-010 SHALL have port cnt  output  16  number of terms in acc.
REQ-011 SHALL have port ovf  output  1  sum exceeded ACC_W bits (sticky per sum).
REQ-012 SHALL have port o_valid  input-side handshake output  1  acc/cnt/ovf are valid.
REQ-013 SHALL have port o_ready  input  1  the consumer takes the result this cycle.

Function
REQ-014 SHALL implement states IDLE (no terms), ACC (at least one term, no last), HOLD (result presented).
REQ-015 SHALL accept a product on each clk edge where p_valid and p_ready are both high.
REQ-016 SHALL drive p_ready = 1 in IDLE and ACC, and p_ready = o_ready in HOLD.
REQ-017 SHALL, on accept in IDLE, load sum = zero-extended p, count = 1, ovf = 0.
REQ-018 SHALL, on accept in ACC, set sum = sum + p modulo 2^ACC_W, count = count + 1 (wraps at 2^16), and set ovf if the addition carries out of ACC_W bits.
REQ-019 SHALL, when the accepted product has p_last = 1, go to HOLD and drive o_valid = 1 with acc/cnt/ovf equal to the final sum, count and flag from the next cycle onward.
REQ-020 SHALL hold acc, cnt and ovf stable while o_valid = 1 and o_ready = 0.
REQ-021 SHALL, in HOLD with o_ready = 1 and no accept, return to IDLE and drive o_valid = 0 the next cycle.
REQ-022 SHALL, in HOLD with o_ready = 1 and a simultaneous accept, start a new sum from that product as in REQ-017. The next state is HOLD if p_last = 1 and ACC otherwise. No cycle is lost.
REQ-023 SHALL treat a single product with p_last = 1 accepted in IDLE as a one-term sum (cnt = 1).
REQ-024 SHALL have a latency of one cycle from accepting the last term to o_valid = 1.
REQ-025 SHALL keep acc, cnt and ovf at their last values whenever o_valid = 0. Only o_valid qualifies them.
REQ-026 SHALL ignore p and p_last when p_valid = 0.

Reset
REQ-027 SHALL, while rst_n = 0, force state = IDLE, o_valid = 0, acc = 0, cnt = 0, ovf = 0, independent of clk.
REQ-028 SHALL discard any partial sum when reset is asserted mid-operation. After release, the first accepted product starts a fresh sum.
REQ-029 SHALL drive p_ready = 1 during reset and on the first cycle after release.

Structure
REQ-030 SHALL take the state encoding (IDLE, ACC, HOLD) and the ACC_W width function from a shared karatsuba package used by the generator's other stages.
REQ-031 SHALL be a single module without sub-modules. It instantiates no multiplier; the parent connects the multiplier output r to p.

Verification
REQ-032 SHALL pass this scenario: N=16, G=8; feed products 3, 5, 7 with p_last on 7 and o_ready=1 -> o_valid=1 one cycle after the third accept, with acc=15, cnt=3, ovf=0.
REQ-033 SHALL pass this scenario: 300 products of 0xFFFF_FFFF with p_last on the last -> acc = (300*(2^32-1)) mod 2^40, ovf=1, cnt=300.
REQ-034 SHALL pass this scenario: result in HOLD with o_ready=0 for 5 cycles and p_valid=1 -> p_ready=0, acc stable, no product consumed.
REQ-035 SHALL pass this scenario: in HOLD, o_ready=1 together with p_valid=1, p=9, p_last=0 -> result taken, state ACC, and the next result sum starts at 9 with cnt=1.
REQ-036 SHALL pass this scenario: rst_n pulsed low mid-sum after 2 terms (4, 6), then feed 10 with p_last=1 -> acc=10, cnt=1.
REQ-037 SHALL pass this scenario: a single product 0x1234 with p_last=1 from IDLE -> acc=0x1234, cnt=1, ovf=0.

Source files
------------

// File: rtl/karatsuba_acc_pkg.sv
// Shared definitions for the Karatsuba generator stages: the accumulator
// state encoding and the accumulator width rule.
package karatsuba_acc_pkg;

    // Accumulator control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no terms collected
        ST_ACC  = 2'd1,   // at least one term, last not yet seen
        ST_HOLD = 2'd2    // finished sum presented downstream
    } kacc_state_t;

    // Width of the term counter presented with each sum
    localparam int CNT_W = 16;

    // Accumulator width: full product width plus guard bits
    function automatic int acc_width(input int n, input int g);
        return 2 * n + g;
    endfunction

endpackage

// File: rtl/karatsuba_acc.sv
// Sums a stream of unsigned products from the Karatsuba multiplier into
// one result per p_last-terminated group. The finished sum, its term count
// and a sticky overflow flag are presented with a valid/ready handshake.
// A new group may begin in the same cycle that the previous result is
// taken, so a continuous product stream never stalls while o_ready is high.
module karatsuba_acc
    import karatsuba_acc_pkg::*;
#(
    parameter int N = 16,
    parameter int G = 8,
    localparam int ACC_W = acc_width(N, G)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*N-1:0]     p,
    input  logic               p_valid,
    input  logic               p_last,
    output logic               p_ready,
    output logic [ACC_W-1:0]   acc,
    output logic [CNT_W-1:0]   cnt,
    output logic               ovf,
    output logic               o_valid,
    input  logic               o_ready
);

    kacc_state_t       state;
    kacc_state_t       state_nxt;

    logic              accept;
    logic              fresh;

    // Running (not yet finished) sum, one register stage behind the input
    logic [ACC_W-1:0]  sum_p1;
    logic [CNT_W-1:0]  cnt_p1;
    logic              ovf_p1;

    logic [ACC_W:0]    add_res;
    logic [ACC_W-1:0]  sum_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf_nxt;

    // Unsigned add that keeps the carry out of the accumulator width in the MSB
    function automatic logic [ACC_W:0] add_carry(input logic [ACC_W-1:0] a,
                                                  input logic [ACC_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign accept = p_valid && p_ready;

    // Next state plus handshake outputs; HOLD back-pressures unless the result is being taken
    always_comb begin
        state_nxt = state;
        p_ready   = 1'b1;
        o_valid   = 1'b0;
        unique case (state)
            ST_IDLE, ST_ACC: begin
                if (p_valid) begin
                    state_nxt = p_last ? ST_HOLD : ST_ACC;
                end
            end
            ST_HOLD: begin
                o_valid = 1'b1;
                p_ready = o_ready;
                if (p_valid && o_ready) begin
                    state_nxt = p_last ? ST_HOLD : ST_ACC;
                end else if (o_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Any accepted term outside ACC opens a new group, so the old running sum is ignored
    always_comb begin
        fresh   = (state != ST_ACC);
        add_res = add_carry(fresh ? '0 : sum_p1, ACC_W'(p));
        sum_nxt = add_res[ACC_W-1:0];
        cnt_nxt = fresh ? CNT_W'(1) : cnt_p1 + CNT_W'(1);
        ovf_nxt = fresh ? 1'b0 : (ovf_p1 | add_res[ACC_W]);
    end

    // State register; reset drops any partial group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- stage p1: running sum, count and carry flag ----
    // Running totals need no reset: the first term after IDLE overwrites them
    always_ff @(posedge clk) begin
        if (accept) begin
            sum_p1 <= sum_nxt;
            cnt_p1 <= cnt_nxt;
            ovf_p1 <= ovf_nxt;
        end
    end

    // ---- output stage: captured only on the last term, held otherwise ----
    // Result registers change only when a group completes, so they stay put while o_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (accept && p_last) begin
            acc <= sum_nxt;
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
        end
    end

    // A presented result must not move while the consumer stalls
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (o_valid && !o_ready) |=> (o_valid && $stable(acc) && $stable(cnt) && $stable(ovf)));

    // Outside HOLD the block always takes products
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !o_valid |-> p_ready);

endmodule

// File: tb/tb_karatsuba_acc.sv
// Bench for karatsuba_acc: directed product groups drive the input side,
// expected results are queued at issue time and a monitor compares every
// taken result, plus cycle-level handshake and hold behaviour.
module tb_karatsuba_acc;

    localparam int N     = 16;
    localparam int G     = 8;
    localparam int ACC_W = 2 * N + G;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2*N-1:0]    p = '0;
    logic              p_valid = 1'b0;
    logic              p_last = 1'b0;
    logic              p_ready;
    logic [ACC_W-1:0]  acc;
    logic [15:0]       cnt;
    logic              ovf;
    logic              o_valid;
    logic              o_ready = 1'b0;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic [15:0]      cnt;
        logic             ovf;
    } res_t;

    res_t exp_q[$];
    logic stim_done = 1'b0;
    int   tests = 0;
    int   fails = 0;

    karatsuba_acc #(.N(N), .G(G)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .p       (p),
        .p_valid (p_valid),
        .p_last  (p_last),
        .p_ready (p_ready),
        .acc     (acc),
        .cnt     (cnt),
        .ovf     (ovf),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    always #5 clk = ~clk;

    // Offer one product and return just after the edge that accepts it
    task automatic send(input logic [2*N-1:0] v, input logic last);
        p       = v;
        p_last  = last;
        p_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (p_ready) break;
        end
        @(posedge clk);
        #1;
        p_valid = 1'b0;
        p_last  = 1'b0;
    endtask

    task automatic expect_result(input logic [ACC_W-1:0] a, input int c, input logic o);
        res_t r;
        r.acc = a;
        r.cnt = 16'(c);
        r.ovf = o;
        exp_q.push_back(r);
    endtask

    // Idle gap with junk on the data lines that must be ignored
    task automatic idle_gap(input int cycles);
        p      = 32'hDEAD_BEEF;
        p_last = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        p_last = 1'b0;
    endtask

    // Stimulus
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        o_ready = 1'b1;

        // 3 + 5 + 7
        expect_result(40'd15, 3, 1'b0);
        send(32'd3, 1'b0);
        send(32'd5, 1'b0);
        send(32'd7, 1'b1);

        // single-term group straight after, taken back-to-back with the previous result
        expect_result(40'h12_34, 1, 1'b0);
        send(32'h1234, 1'b1);
        idle_gap(3);

        // 300 x 0xFFFF_FFFF overflows 40 bits
        expect_result(40'h2B_FFFF_FED4, 300, 1'b1);
        for (int i = 0; i < 300; i++) begin
            send(32'hFFFF_FFFF, (i == 299));
        end
        idle_gap(2);

        // result held with consumer stalled, then taken together with a new term 9
        o_ready = 1'b0;
        expect_result(40'd3, 2, 1'b0);
        send(32'd1, 1'b0);
        send(32'd2, 1'b1);
        p       = 32'd9;
        p_last  = 1'b0;
        p_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        o_ready = 1'b1;
        expect_result(40'd13, 2, 1'b0);
        send(32'd9, 1'b0);
        send(32'd4, 1'b1);
        idle_gap(2);

        // reset mid-group discards 4 + 6
        send(32'd4, 1'b0);
        send(32'd6, 1'b0);
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_result(40'd10, 1, 1'b0);
        send(32'd10, 1'b1);

        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        stim_done = 1'b1;
    end

    // Monitor: per-cycle handshake model, hold checks and scoreboard pops
    initial begin
        logic pv_rst;
        logic pv_ov;
        logic pv_or;
        logic pv_al;
        logic exp_ov;
        res_t pv_res;
        res_t cur;
        res_t e;
        int   cyc;
        pv_rst = 1'b0;
        pv_ov  = 1'b0;
        pv_or  = 1'b0;
        pv_al  = 1'b0;
        pv_res = '0;
        cyc    = 0;
        forever begin
            @(negedge clk);
            cyc++;
            cur = {acc, cnt, ovf};
            if (cyc > 20000) begin
                tests++;
                fails++;
                $display("FAIL watchdog: %0d cycles elapsed, need stimulus done before 20000", cyc);
                break;
            end
            if (stim_done) begin
                tests++;
                if (exp_q.size() != 0) begin
                    fails++;
                    $display("FAIL drain: %0d results never presented, need 0", exp_q.size());
                end
                break;
            end
            if (!rst_n) begin
                tests++;
                if (cur !== '0 || o_valid !== 1'b0 || p_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL reset: acc=%0h cnt=%0d ovf=%0b o_valid=%0b p_ready=%0b, need all 0 with p_ready=1",
                             acc, cnt, ovf, o_valid, p_ready);
                end
            end else begin
                tests++;
                if (p_ready !== (!o_valid || o_ready)) begin
                    fails++;
                    $display("FAIL p_ready: got %0b, need %0b (o_valid=%0b o_ready=%0b)",
                             p_ready, (!o_valid || o_ready), o_valid, o_ready);
                end
                if (pv_rst) begin
                    exp_ov = pv_al | (pv_ov & ~pv_or);
                    tests++;
                    if (o_valid !== exp_ov) begin
                        fails++;
                        $display("FAIL o_valid: got %0b, need %0b at cycle %0d", o_valid, exp_ov, cyc);
                    end
                    if (!pv_al) begin
                        tests++;
                        if (cur !== pv_res) begin
                            fails++;
                            $display("FAIL hold: acc=%0h cnt=%0d ovf=%0b, need unchanged acc=%0h cnt=%0d ovf=%0b",
                                     acc, cnt, ovf, pv_res.acc, pv_res.cnt, pv_res.ovf);
                        end
                    end
                end
                if (o_valid && o_ready) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL result: unexpected acc=%0h cnt=%0d ovf=%0b, need none", acc, cnt, ovf);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            fails++;
                            $display("FAIL result: got acc=%0h cnt=%0d ovf=%0b, need acc=%0h cnt=%0d ovf=%0b",
                                     acc, cnt, ovf, e.acc, e.cnt, e.ovf);
                        end
                    end
                end
            end
            pv_rst = rst_n;
            pv_ov  = o_valid;
            pv_or  = o_ready;
            pv_al  = p_valid & p_ready & p_last;
            pv_res = cur;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
